// File: rtl/dec_pkg.sv
// Shared types and helpers for the dec_nx_scan one-hot decoder.
// Optional wrap pulse output is enabled by defining DEC_WRAP_EN.
package dec_pkg;

  typedef enum logic [1:0] {
    DEC_OFF,
    DEC_DIRECT,
    DEC_SCAN
  } dec_state_t;

  localparam logic DEC_M_DIRECT = 1'b0;
  localparam logic DEC_M_SCAN   = 1'b1;

  function automatic int dec_cnt_w(input int dwell);
    return (dwell <= 1) ? 1 : $clog2(dwell);
  endfunction

endpackage

// File: rtl/dec_onehot.sv
// Combinational index to one-hot decode with an enable gate.
// The caller registers the result.
module dec_onehot #(
  parameter int SEL_W = 2,
  localparam int N    = 2 ** SEL_W
) (
  input  logic [SEL_W-1:0] idx_i,
  input  logic             en_i,
  output logic [N-1:0]     oh_o
);

  always_comb begin
    oh_o = '0;
    if (en_i) oh_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/dec_nx_scan.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with DIRECT and SCAN modes.
// Define DEC_WRAP_EN to get the wrap pulse port.
module dec_nx_scan
  import dec_pkg::*;
#(
  parameter int SEL_W = 2,
  parameter int DWELL = 1,
  localparam int N    = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             e,
  input  logic             m,
  input  logic [SEL_W-1:0] s,
  output logic [N-1:0]     o,
  output logic [SEL_W-1:0] idx
`ifdef DEC_WRAP_EN
  ,
  output logic             wrap
`endif
);

  localparam int CW = dec_cnt_w(DWELL);
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = {SEL_W{1'b1}};

  dec_state_t       state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N-1:0]     o_q, oh_d;
  logic             adv;

  always_comb begin
    if (!e)                     state_d = DEC_OFF;
    else if (m == DEC_M_DIRECT) state_d = DEC_DIRECT;
    else                        state_d = DEC_SCAN;
  end

  always_comb begin
    idx_d = idx_q;
    cnt_d = '0;
    adv   = 1'b0;
    unique case (state_d)
      DEC_OFF:    idx_d = idx_q;
      DEC_DIRECT: idx_d = s;
      DEC_SCAN: begin
        // Entering SCAN always restarts from s with a fresh dwell.
        if (state_q != DEC_SCAN) begin
          idx_d = s;
        end else if (cnt_q == CNT_LAST) begin
          adv   = 1'b1;
          idx_d = idx_q + SEL_W'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: idx_d = idx_q;
    endcase
  end

  dec_onehot #(.SEL_W(SEL_W)) u_onehot (
    .idx_i (idx_d),
    .en_i  (state_d != DEC_OFF),
    .oh_o  (oh_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DEC_OFF;
      idx_q   <= '0;
      cnt_q   <= '0;
      o_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      o_q     <= oh_d;
    end
  end

  assign o   = o_q;
  assign idx = idx_q;

`ifdef DEC_WRAP_EN
  logic wrap_q;

  always_ff @(posedge clk) begin
    if (rst) wrap_q <= 1'b0;
    else     wrap_q <= adv && (idx_q == IDX_LAST);
  end

  assign wrap = wrap_q;
`else
  logic unused_adv;
  assign unused_adv = adv ^ (IDX_LAST == '0);
`endif

endmodule

// File: tb/tb_dec_nx_scan.sv
// Self-checking bench for dec_nx_scan: three instances with different
// SEL_W/DWELL share stimulus and are checked against a behavioural model.
module tb_dec_nx_scan;

  logic       clk = 1'b0;
  logic       rst, e, m;
  logic [1:0] s_ab;
  logic [2:0] s_c;

  logic [3:0] o_a, o_b;
  logic [7:0] o_c;
  logic [1:0] idx_a, idx_b;
  logic [2:0] idx_c;
`ifdef DEC_WRAP_EN
  logic wrap_a, wrap_b, wrap_c;
`endif

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dec_nx_scan #(.SEL_W(2), .DWELL(1)) u_a (
    .clk(clk), .rst(rst), .e(e), .m(m), .s(s_ab), .o(o_a), .idx(idx_a)
`ifdef DEC_WRAP_EN
    , .wrap(wrap_a)
`endif
  );

  dec_nx_scan #(.SEL_W(2), .DWELL(3)) u_b (
    .clk(clk), .rst(rst), .e(e), .m(m), .s(s_ab), .o(o_b), .idx(idx_b)
`ifdef DEC_WRAP_EN
    , .wrap(wrap_b)
`endif
  );

  dec_nx_scan #(.SEL_W(3), .DWELL(2)) u_c (
    .clk(clk), .rst(rst), .e(e), .m(m), .s(s_c), .o(o_c), .idx(idx_c)
`ifdef DEC_WRAP_EN
    , .wrap(wrap_c)
`endif
  );

  // Model: mode 0=off 1=direct 2=scan; held = clocks spent at current position.
  int W [3] = '{2, 2, 3};
  int D [3] = '{1, 3, 2};
  int mmode [3];
  int midx  [3];
  int mheld [3];
  int mwrap [3];

  logic [7:0] obs_o [3];
  logic [7:0] obs_i [3];
  logic       obs_w [3];

  always_comb begin
    obs_o[0] = {4'b0, o_a};
    obs_o[1] = {4'b0, o_b};
    obs_o[2] = o_c;
    obs_i[0] = {6'b0, idx_a};
    obs_i[1] = {6'b0, idx_b};
    obs_i[2] = {5'b0, idx_c};
`ifdef DEC_WRAP_EN
    obs_w[0] = wrap_a;
    obs_w[1] = wrap_b;
    obs_w[2] = wrap_c;
`else
    obs_w[0] = 1'b0;
    obs_w[1] = 1'b0;
    obs_w[2] = 1'b0;
`endif
  end

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit ee, input bit mm,
                            input logic [2:0] sv);
    for (int k = 0; k < 3; k++) begin
      int n, sk;
      n  = 1 << W[k];
      sk = int'(sv) % n;
      if (r) begin
        mmode[k] = 0; midx[k] = 0; mheld[k] = 0; mwrap[k] = 0;
      end else if (!ee) begin
        mmode[k] = 0; mheld[k] = 0; mwrap[k] = 0;
      end else if (!mm) begin
        mmode[k] = 1; midx[k] = sk; mheld[k] = 0; mwrap[k] = 0;
      end else if (mmode[k] != 2) begin
        mmode[k] = 2; midx[k] = sk; mheld[k] = 1; mwrap[k] = 0;
      end else if (mheld[k] == D[k]) begin
        midx[k]  = (midx[k] + 1) % n;
        mheld[k] = 1;
        mwrap[k] = (midx[k] == 0) ? 1 : 0;
      end else begin
        mheld[k]++;
        mwrap[k] = 0;
      end
    end
  endtask

  task automatic step(input bit r, input bit ee, input bit mm,
                      input logic [2:0] sv);
    rst = r; e = ee; m = mm; s_ab = sv[1:0]; s_c = sv;
    @(posedge clk);
    model_edge(r, ee, mm, sv);
    #1;
    for (int k = 0; k < 3; k++) begin
      logic [7:0] eo;
      eo = (mmode[k] != 0) ? 8'(1 << midx[k]) : 8'h00;
      chk($sformatf("o[%0d]", k), obs_o[k], eo);
      chk($sformatf("idx[%0d]", k), obs_i[k], 8'(midx[k]));
      chk($sformatf("onehot[%0d]", k),
          8'($countones(obs_o[k])), (mmode[k] != 0) ? 8'd1 : 8'd0);
`ifdef DEC_WRAP_EN
      chk($sformatf("wrap[%0d]", k), {7'b0, obs_w[k]}, 8'(mwrap[k]));
`endif
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      mmode[k] = 0; midx[k] = 0; mheld[k] = 0; mwrap[k] = 0;
    end

    // Reset held for two clocks with e=1, m=1.
    step(1, 1, 1, 3'd2);
    step(1, 1, 1, 3'd2);
    chk("rst_o", {4'b0, o_a}, 8'h00);
    chk("rst_idx", {6'b0, idx_a}, 8'h00);

    // Release: SCAN entry at s=2, DWELL=1 advances every clock.
    step(0, 1, 1, 3'd2);
    chk("scan1_entry", {4'b0, o_a}, 8'b0100);
    step(0, 1, 1, 3'd0);
    chk("scan1_a", {4'b0, o_a}, 8'b1000);
    step(0, 1, 1, 3'd0);
    chk("scan1_wrap", {4'b0, o_a}, 8'b0001);
    step(0, 1, 1, 3'd0);
    chk("scan1_b", {4'b0, o_a}, 8'b0010);
    step(0, 1, 1, 3'd0);
    chk("scan1_c", {4'b0, o_a}, 8'b0100);

    // DIRECT sweep.
    step(0, 1, 0, 3'd0);
    chk("dir_0", {4'b0, o_a}, 8'b0001);
    step(0, 1, 0, 3'd2);
    chk("dir_2", {4'b0, o_a}, 8'b0100);
    step(0, 1, 0, 3'd1);
    chk("dir_1", {4'b0, o_a}, 8'b0010);
    step(0, 1, 0, 3'd3);
    chk("dir_3", {4'b0, o_b}, 8'b1000);

    // DWELL=3 scan from 0: each position held 3 clocks.
    for (int i = 0; i < 13; i++) begin
      step(0, 1, 1, 3'd0);
      chk("dwell3", {4'b0, o_b}, 8'(1 << ((i / 3) % 4)));
    end

    // Mid-scan events on the DWELL=3 instance.
    step(0, 1, 0, 3'd0);
    step(0, 1, 1, 3'd0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 3'd0);
    chk("mid_idx1", {6'b0, idx_b}, 8'd1);
    step(0, 0, 1, 3'd0);
    chk("mid_off", {4'b0, o_b}, 8'h00);
    step(0, 1, 1, 3'd3);
    chk("mid_reen", {4'b0, o_b}, 8'b1000);
    step(0, 1, 1, 3'd0);
    chk("mid_hold", {4'b0, o_b}, 8'b1000);
    step(0, 1, 0, 3'd0);
    chk("mid_dir", {4'b0, o_b}, 8'b0001);

    // Reset mid-scan at idx=2.
    step(0, 1, 1, 3'd2);
    step(0, 1, 1, 3'd0);
    step(0, 1, 1, 3'd0);
    chk("pre_rst", {6'b0, idx_b}, 8'd2);
    step(1, 1, 1, 3'd0);
    chk("mrst_o", {4'b0, o_b}, 8'h00);
    chk("mrst_idx", {6'b0, idx_b}, 8'd0);
    step(0, 1, 1, 3'd1);
    chk("post_rst", {4'b0, o_b}, 8'b0010);

    // SEL_W=3 instance through a full wrap.
    step(0, 1, 0, 3'd0);
    step(0, 1, 1, 3'd5);
    chk("w3_entry", o_c, 8'h20);
    for (int i = 0; i < 6; i++) step(0, 1, 1, 3'd0);
    chk("w3_wrap", o_c, 8'h01);
    for (int i = 0; i < 14; i++) step(0, 1, 1, 3'd0);

    // Randomised phase.
    for (int i = 0; i < 400; i++) begin
      bit r, ee, mm;
      r  = ($urandom_range(0, 29) == 0);
      ee = ($urandom_range(0, 9) != 0);
      mm = ($urandom_range(0, 9) < 7);
      step(r, ee, mm, 3'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
